ram2_arbiter: RTL and testbench

Arbiter and sequencer for the shared single-port RAM2 SRAM. Instruction fetch (IF) and the MEM stage both read RAM2; the MEM stage also writes it. The block grants one requester at a time and drives the SRAM control pins with registered, glitch-free timing. It returns read data with a one-cycle ready pulse and raises a stall request to the pipeline control while any requester is waiting.

---
 rtl/ram2_arbiter_pkg.sv | 54 +++++
 rtl/ram2_arbiter_fsm.sv | 55 +++++
 rtl/ram2_arbiter.sv | 103 ++++++++++
 tb/tb_ram2_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram2_arbiter_pkg.sv
// Shared types and constants for the RAM2 arbiter: FSM states, owner encoding,
// the MEM chip-enable value that selects RAM2, and the SRAM control-pin set per state.
package ram2_arbiter_pkg;

  typedef enum logic [2:0] {
    RAM2_IDLE = 3'd0,
    RAM2_RD1  = 3'd1,
    RAM2_RD2  = 3'd2,
    RAM2_WR1  = 3'd3,
    RAM2_WR2  = 3'd4,
    RAM2_WR3  = 3'd5,
    RAM2_DONE = 3'd6
  } ram2_state_e;

  typedef enum logic {
    RAM2_OWNER_IF  = 1'b0,
    RAM2_OWNER_MEM = 1'b1
  } ram2_owner_e;

  localparam logic RAM_RAM2_CHIP_ENABLE = 1'b1;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic data_oe;
  } sram_ctrl_t;

  localparam sram_ctrl_t SRAM_CTRL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0};

  // Control pins that must be present while the FSM sits in state s.
  function automatic sram_ctrl_t sram_ctrl_for(input ram2_state_e s);
    sram_ctrl_t c;
    c = SRAM_CTRL_IDLE;
    case (s)
      RAM2_RD1, RAM2_RD2: begin
        c.ce_n = 1'b0;
        c.oe_n = 1'b0;
      end
      RAM2_WR1, RAM2_WR3: begin
        c.ce_n    = 1'b0;
        c.data_oe = 1'b1;
      end
      RAM2_WR2: begin
        c.ce_n    = 1'b0;
        c.we_n    = 1'b0;
        c.data_oe = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram2_arbiter_fsm.sv
// Grant/sequencing FSM for RAM2: fixed MEM-over-IF priority in IDLE, fixed-length
// read and write sequences, and a mandatory DONE cycle before the next grant.
module ram2_arbiter_fsm
  import ram2_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_pending,
  input  logic        mem_write,
  input  logic        if_req,
  output ram2_state_e state,
  output ram2_state_e next_state,
  output ram2_owner_e owner,
  output ram2_owner_e next_owner,
  output logic        grant
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RAM2_IDLE;
      owner <= RAM2_OWNER_IF;
    end else begin
      state <= next_state;
      owner <= next_owner;
    end
  end

  // Every non-IDLE state advances unconditionally, so a misbehaving requester can never stall the FSM.
  always_comb begin
    next_state = state;
    next_owner = owner;
    grant      = 1'b0;
    case (state)
      RAM2_IDLE: begin
        if (mem_pending) begin
          grant      = 1'b1;
          next_owner = RAM2_OWNER_MEM;
          next_state = mem_write ? RAM2_WR1 : RAM2_RD1;
        end else if (if_req) begin
          grant      = 1'b1;
          next_owner = RAM2_OWNER_IF;
          next_state = RAM2_RD1;
        end
      end
      RAM2_RD1: next_state = RAM2_RD2;
      RAM2_RD2: next_state = RAM2_DONE;
      RAM2_WR1: next_state = RAM2_WR2;
      RAM2_WR2: next_state = RAM2_WR3;
      RAM2_WR3: next_state = RAM2_DONE;
      RAM2_DONE: next_state = RAM2_IDLE;
      default: next_state = RAM2_IDLE;
    endcase
  end

endmodule

// File: rtl/ram2_arbiter.sv
// RAM2 arbiter top: shares the single-port SRAM between IF reads and MEM reads/writes,
// drives all SRAM pins from registers and returns data with a one-cycle ready pulse.
module ram2_arbiter
  import ram2_arbiter_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_ready_o,
  input  logic              mem_ce_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_oe,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  logic        mem_pending;
  logic        grant;
  logic        unused_addr_bits;
  ram2_state_e state;
  ram2_state_e next_state;
  ram2_owner_e owner;
  ram2_owner_e next_owner;
  sram_ctrl_t  ctrl_q;

  assign mem_pending      = (mem_ce_i == RAM_RAM2_CHIP_ENABLE) && (mem_re_i || mem_we_i);
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  ram2_arbiter_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_pending (mem_pending),
    .mem_write   (mem_we_i),
    .if_req      (if_req_i),
    .state       (state),
    .next_state  (next_state),
    .owner       (owner),
    .next_owner  (next_owner),
    .grant       (grant)
  );

  // Pins are registered from the state being entered, so they change only on clock edges
  // and address/data are latched once at grant; we_n therefore never falls with an address change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q      <= SRAM_CTRL_IDLE;
      sram_addr_o <= '0;
      sram_data_o <= '0;
    end else begin
      ctrl_q <= sram_ctrl_for(next_state);
      if (grant) begin
        sram_addr_o <= (next_owner == RAM2_OWNER_MEM) ? mem_addr_i[ADDR_W-1:0]
                                                      : if_addr_i[ADDR_W-1:0];
        if (next_state == RAM2_WR1) begin
          sram_data_o <= mem_data_i;
        end
      end
    end
  end

  // Read data is sampled at the end of RD2 so it appears together with the DONE ready pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_inst_o   <= '0;
      mem_data_o  <= '0;
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
    end else begin
      if_ready_o  <= (next_state == RAM2_DONE) && (owner == RAM2_OWNER_IF);
      mem_ready_o <= (next_state == RAM2_DONE) && (owner == RAM2_OWNER_MEM);
      if (state == RAM2_RD2) begin
        if (owner == RAM2_OWNER_IF) begin
          if_inst_o <= sram_data_i;
        end else begin
          mem_data_o <= sram_data_i;
        end
      end
    end
  end

  assign sram_ce_n    = ctrl_q.ce_n;
  assign sram_oe_n    = ctrl_q.oe_n;
  assign sram_we_n    = ctrl_q.we_n;
  assign sram_data_oe = ctrl_q.data_oe;

  assign stall_req_o = (if_req_i && !if_ready_o) || (mem_pending && !mem_ready_o);

endmodule

// File: tb/tb_ram2_arbiter.sv
// Self-checking bench for ram2_arbiter: directed scenarios with literal expectations,
// then random IF/MEM requesters checked every cycle against a transaction-level model.
module tb_ram2_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        if_ready_o;
  logic        mem_ce_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        stall_req_o;
  logic [17:0] sram_addr_o;
  logic [31:0] sram_data_o;
  logic        sram_data_oe;
  logic [31:0] sram_data_i;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int total = 0;
  int bad   = 0;

  logic [31:0] sram_mem [0:4095];
  logic [31:0] ref_mem  [0:4095];

  // Transaction-level model state
  int          cyc = 0;
  int          next_free = 0;
  bit          m_active = 0;
  int          m_g = 0;
  int          m_len = 0;
  bit          m_mem = 0;
  bit          m_write = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] last_if = '0;
  logic [31:0] last_mem = '0;

  bit rand_on = 0;
  bit rand_stop = 0;
  bit if_busy = 0;
  bit mem_busy = 0;
  int mem_kind = 0;

  ram2_arbiter #(.ADDR_W(18), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_inst_o    (if_inst_o),
    .if_ready_o   (if_ready_o),
    .mem_ce_i     (mem_ce_i),
    .mem_re_i     (mem_re_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o),
    .mem_ready_o  (mem_ready_o),
    .stall_req_o  (stall_req_o),
    .sram_addr_o  (sram_addr_o),
    .sram_data_o  (sram_data_o),
    .sram_data_oe (sram_data_oe),
    .sram_data_i  (sram_data_i),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: 4096 words, read data valid while oe_n is low, write on rising we_n.
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr_o[11:0]] : 32'h0BAD_0BAD;

  always @(posedge sram_we_n) begin
    if (rst && !sram_ce_n && sram_data_oe) sram_mem[sram_addr_o[11:0]] = sram_data_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic ce,
                               input logic re, input logic we, input logic [31:0] ma,
                               input logic [31:0] md);
    if_req_i   = ifr;
    if_addr_i  = ifa;
    mem_ce_i   = ce;
    mem_re_i   = re;
    mem_we_i   = we;
    mem_addr_i = ma;
    mem_data_i = md;
  endtask

  function automatic logic [31:0] randAddr();
    return ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15));
  endfunction

  // Model: a grant happens at the end of any cycle at or after next_free with a request
  // pending (MEM first); the access takes 3 (read) or 4 (write) cycles to its ready pulse.
  always @(posedge clk) begin
    if (!rst) begin
      m_active  = 0;
      next_free = 0;
      last_if   = '0;
      last_mem  = '0;
    end else begin
      bit mp;
      mp = (mem_ce_i == 1'b1) && (mem_re_i || mem_we_i);
      if (cyc >= next_free && (mp || if_req_i)) begin
        m_active  = 1;
        m_g       = cyc;
        m_mem     = mp;
        m_write   = mp && mem_we_i;
        m_len     = m_write ? 4 : 3;
        m_addr    = mp ? mem_addr_i : if_addr_i;
        m_wdata   = mem_data_i;
        m_rdata   = ref_mem[m_addr[11:0]];
        next_free = cyc + m_len + 1;
      end
    end
    cyc++;
  end

  // Compare process: every cycle, DUT outputs against the model's view of that cycle.
  always @(negedge clk) begin
    int off;
    logic e_ce, e_oe, e_we, e_doe, e_ifr, e_memr, e_stall, mp;
    e_ce = 1; e_oe = 1; e_we = 1; e_doe = 0; e_ifr = 0; e_memr = 0;
    if (m_active) begin
      off = cyc - m_g;
      if (off >= 1 && off < m_len) begin
        e_ce = 0;
        if (m_write) begin
          e_doe = 1;
          e_we  = (off == 2) ? 1'b0 : 1'b1;
          checkOutput("model_wdata", sram_data_o, m_wdata);
        end else begin
          e_oe = 0;
        end
        checkOutput("model_addr", {14'd0, sram_addr_o}, {14'd0, m_addr[17:0]});
      end else if (off == m_len) begin
        if (m_mem) begin
          e_memr = 1;
          if (m_write) ref_mem[m_addr[11:0]] = m_wdata;
          else last_mem = m_rdata;
        end else begin
          e_ifr   = 1;
          last_if = m_rdata;
        end
      end
    end
    mp      = (mem_ce_i == 1'b1) && (mem_re_i || mem_we_i);
    e_stall = (if_req_i && !e_ifr) || (mp && !e_memr);
    checkOutput("model_ce_n", {31'd0, sram_ce_n}, {31'd0, e_ce});
    checkOutput("model_oe_n", {31'd0, sram_oe_n}, {31'd0, e_oe});
    checkOutput("model_we_n", {31'd0, sram_we_n}, {31'd0, e_we});
    checkOutput("model_data_oe", {31'd0, sram_data_oe}, {31'd0, e_doe});
    checkOutput("model_if_ready", {31'd0, if_ready_o}, {31'd0, e_ifr});
    checkOutput("model_mem_ready", {31'd0, mem_ready_o}, {31'd0, e_memr});
    checkOutput("model_if_inst", if_inst_o, last_if);
    checkOutput("model_mem_data", mem_data_o, last_mem);
    checkOutput("model_stall", {31'd0, stall_req_o}, {31'd0, e_stall});
  end

  // Random IF requester: holds its request until the ready pulse, may re-request at once.
  always @(negedge clk) begin
    #1;
    if (rand_on) begin
      if (if_busy && if_ready_o) begin
        if_busy  = 0;
        if_req_i = 1'b0;
      end
      if (!if_busy && !rand_stop && $urandom_range(0, 2) == 0) begin
        if_busy   = 1;
        if_req_i  = 1'b1;
        if_addr_i = randAddr();
      end
    end
  end

  // Random MEM requester: reads, writes, both-high writes and chip-enable-inactive noise.
  always @(negedge clk) begin
    #1;
    if (rand_on) begin
      if (mem_busy) begin
        if (mem_ready_o) begin
          mem_busy = 0;
          mem_re_i = 1'b0;
          mem_we_i = 1'b0;
        end
      end else begin
        mem_ce_i = 1'b1;
        mem_re_i = 1'b0;
        mem_we_i = 1'b0;
      end
      if (!mem_busy && !rand_stop && $urandom_range(0, 2) == 0) begin
        mem_kind   = int'($urandom_range(0, 5));
        mem_addr_i = randAddr();
        mem_data_i = $urandom;
        if (mem_kind == 0) begin
          mem_ce_i = 1'b0;
          mem_re_i = 1'b1;
          mem_we_i = 1'($urandom_range(0, 1));
        end else begin
          mem_busy = 1;
          mem_ce_i = 1'b1;
          mem_we_i = (mem_kind >= 3);
          mem_re_i = (mem_kind <= 3);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[12'h004] = 32'h3C01_1234; ref_mem[12'h004] = 32'h3C01_1234;
    sram_mem[12'h020] = 32'h1111_2222; ref_mem[12'h020] = 32'h1111_2222;
    sram_mem[12'h024] = 32'h3333_4444; ref_mem[12'h024] = 32'h3333_4444;
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    checkOutput("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    checkOutput("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("rst_data_oe", {31'd0, sram_data_oe}, 32'd0);
    checkOutput("rst_addr", {14'd0, sram_addr_o}, 32'd0);
    checkOutput("rst_sram_data", sram_data_o, 32'd0);
    checkOutput("rst_if_inst", if_inst_o, 32'd0);
    checkOutput("rst_mem_data", mem_data_o, 32'd0);
    checkOutput("rst_readies", {30'd0, if_ready_o, mem_ready_o}, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    // IF read of word 0x004
    applyStimulus(1, 32'h4, 1, 0, 0, 0, 0);
    #1 checkOutput("ifrd_stall_c0", {31'd0, stall_req_o}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("ifrd_ready", {31'd0, if_ready_o}, (k == 3) ? 32'd1 : 32'd0);
      checkOutput("ifrd_stall", {31'd0, stall_req_o}, (k == 3) ? 32'd0 : 32'd1);
    end
    checkOutput("ifrd_inst", if_inst_o, 32'h3C01_1234);
    #1 if_req_i = 1'b0;
    @(negedge clk); #1;

    // MEM write 0xDEADBEEF to 0x010, then read it back
    applyStimulus(0, 0, 1, 0, 1, 32'h10, 32'hDEAD_BEEF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 3) checkOutput("wr_we_n", {31'd0, sram_we_n}, (k == 2) ? 32'd0 : 32'd1);
      checkOutput("wr_ready", {31'd0, mem_ready_o}, (k == 4) ? 32'd1 : 32'd0);
    end
    #1 mem_we_i = 1'b0;
    @(negedge clk); #1;
    applyStimulus(0, 0, 1, 1, 0, 32'h10, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("rdback_ready", {31'd0, mem_ready_o}, (k == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("rdback_data", mem_data_o, 32'hDEAD_BEEF);
    #1 mem_re_i = 1'b0;
    @(negedge clk); #1;

    // Contention: MEM read of 0x024 and IF read of 0x020 raised together
    applyStimulus(1, 32'h20, 1, 1, 0, 32'h24, 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checkOutput("cont_no_overlap", {31'd0, !sram_oe_n && sram_data_oe}, 32'd0);
      checkOutput("cont_mem_ready", {31'd0, mem_ready_o}, (k == 3) ? 32'd1 : 32'd0);
      checkOutput("cont_if_ready", {31'd0, if_ready_o}, (k == 7) ? 32'd1 : 32'd0);
      if (k == 3) begin
        checkOutput("cont_mem_data", mem_data_o, 32'h3333_4444);
        #1 mem_re_i = 1'b0;
      end
    end
    checkOutput("cont_if_inst", if_inst_o, 32'h1111_2222);
    #1 if_req_i = 1'b0;
    @(negedge clk); #1;

    // MEM read with chip enable inactive alongside an IF read
    applyStimulus(1, 32'h4, 0, 1, 0, 32'h24, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("ce_off_mem_ready", {31'd0, mem_ready_o}, 32'd0);
      checkOutput("ce_off_if_ready", {31'd0, if_ready_o}, (k == 3) ? 32'd1 : 32'd0);
      if (k >= 4) checkOutput("ce_off_idle", {31'd0, sram_ce_n}, 32'd1);
      if (k == 3) #1 if_req_i = 1'b0;
    end
    checkOutput("ce_off_stall", {31'd0, stall_req_o}, 32'd0);
    #1 mem_re_i = 1'b0;
    mem_ce_i = 1'b1;
    @(negedge clk); #1;

    // Reset asserted during WR2 aborts the write
    applyStimulus(0, 0, 1, 0, 1, 32'h30, 32'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstwr_we_low", {31'd0, sram_we_n}, 32'd0);
    #1 rst = 1'b0;
    #1;
    checkOutput("rstwr_we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("rstwr_data_oe", {31'd0, sram_data_oe}, 32'd0);
    checkOutput("rstwr_ce_n", {31'd0, sram_ce_n}, 32'd1);
    mem_we_i = 1'b0;
    @(negedge clk);
    checkOutput("rstwr_no_ready", {31'd0, mem_ready_o}, 32'd0);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rstwr_after_ready", {31'd0, mem_ready_o}, 32'd0);
      checkOutput("rstwr_after_ce_n", {31'd0, sram_ce_n}, 32'd1);
    end
    #1 applyStimulus(1, 32'h4, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("rstwr_idle_read", {31'd0, if_ready_o}, (k == 3) ? 32'd1 : 32'd0);
    end
    #1 if_req_i = 1'b0;
    @(negedge clk);

    // Random traffic from both requesters
    $display("[TB] starting random traffic");
    rand_on = 1;
    repeat (3000) @(negedge clk);
    rand_stop = 1;
    repeat (25) @(negedge clk);
    rand_on = 0;
    checkOutput("drain_if_idle", {31'd0, if_busy}, 32'd0);
    checkOutput("drain_mem_idle", {31'd0, mem_busy}, 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
